demux_stream: RTL and testbench
===============================

Name: demux_stream

Overview:
- Parametrised 1:NUM_OUT streaming demultiplexer. It is the registered, flow-controlled successor to the combinational 1:2 data demux.
- Each accepted input word is routed to the output channel named by in_sel, or copied to all channels in broadcast mode.
- Every channel has its own DEPTH-entry FIFO, so one stalled consumer does not block traffic to the others.
- Sits between a single producer and several consumers that use valid/ready handshakes.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- NUM_OUT, 2, number of output channels (>=2).
- DEPTH, 2, entries per channel FIFO (power of 2, >=2).
- Derived, not overridable: SEL_W = max(1, ceil(log2(NUM_OUT))); CNT_W = log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  input word.
- in_sel  input  SEL_W  destination channel index; sampled with in_data.
- in_bcast  input  1  1 = write the word to every channel; in_sel is ignored.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept this cycle.
- out_data  output  NUM_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  NUM_OUT  channel k FIFO non-empty.
- out_ready  input  NUM_OUT  consumer k takes its head word.
- out_level  output  NUM_OUT*CNT_W  occupancy of channel k, bits [k*CNT_W +: CNT_W].
- bad_sel  output  1  sticky flag: a unicast word was addressed to in_sel >= NUM_OUT.

Behaviour:
- Reset, asynchronous on rst_n low:
  - all FIFOs empty; out_valid=0, out_data=0, out_level=0, bad_sel=0.
  - in_ready=0 while rst_n is low; in_ready is valid from the first edge after release.
  - Reset mid-transfer discards all stored words with no partial output.
- Accept: a word is accepted on a rising edge where in_valid && in_ready.
- in_ready, combinational from registered state only (no path from out_ready):
  - unicast, in_sel < NUM_OUT: in_ready = (level[in_sel] < DEPTH).
  - unicast, in_sel >= NUM_OUT: in_ready = 1. The word is accepted and discarded; bad_sel sets on that edge and holds until reset.
  - broadcast: in_ready = all channels have level < DEPTH. Write is all-or-nothing; no partial broadcast.
- Latency: an accepted word is visible at the target out_data/out_valid on the cycle after the accept edge (1 cycle). No same-cycle bypass.
- Pop: channel k pops on a rising edge where out_valid[k] && out_ready[k]. The next word, if any, appears the following cycle.
- out_data for channel k = FIFO head when out_valid[k]=1, else all zeros. Idle outputs are zero-filled, as in the combinational demux. out_data is stable while out_valid && !out_ready.
- Simultaneous push and pop on the same channel:
  - level unchanged, ordering preserved.
  - A full channel still shows in_ready=0 that cycle, even if it is popping.
- Per-channel FIFO: circular buffer with read/write pointers wrapping modulo DEPTH. level counts 0..DEPTH inclusive.
- Order: strict FIFO per channel. There is no ordering guarantee across channels.
- in_valid low: no state change except pops. in_sel and in_bcast are ignored when in_valid=0.
- No X propagation: out_data is driven from registers or zero, never from unwritten storage.

Test Plan:
- Unicast routing, NUM_OUT=4, all out_ready=1: send 0x11 sel0, 0x22 sel3, 0x33 sel1 on consecutive cycles.
  - Each appears one cycle later on its own channel only; other channels read 0x00 with valid=0.
- Backpressure, DEPTH=2, out_ready[0]=0: send 0xA1, 0xA2, 0xA3 to ch0.
  - First two accepted; level0=2; in_ready=0 for the third.
  - While ch0 is stalled, a word to ch1 is still accepted.
  - Raising out_ready[0] drains A1 then A2, and A3 is then accepted.
- Broadcast with one full channel: fill ch2 to DEPTH, then send bcast 0x5C.
  - in_ready=0 and no channel changes.
  - Pop one ch2 entry; 0x5C is accepted and appears on all NUM_OUT channels the next cycle.
- Simultaneous push/pop: ch0 at level 1 with out_ready[0]=1 and a new push to ch0 in the same cycle.
  - level stays 1; the old head leaves, the new word becomes head next cycle.
  - Repeat for 2*DEPTH+1 cycles to exercise pointer wrap with no loss or reorder.
- Invalid select, NUM_OUT=3: send 0x77 with sel=3.
  - Accepted (in_ready=1), no out_valid change, bad_sel=1 and held.
  - A following valid word routes normally.
- Reset mid-operation: with ch0 and ch1 holding data, pulse rst_n low between clock edges.
  - Outputs go to 0 immediately (asynchronous): out_valid=0, out_level=0, bad_sel=0.
  - in_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/demux_stream.sv
// demux_stream: 1:NUM_OUT streaming demultiplexer with one FIFO per channel.
// Each accepted word goes to the channel chosen by in_sel, or to every
// channel in broadcast mode. Each channel has its own FIFO, so a stalled
// consumer only holds back traffic that is addressed to that channel.
module demux_stream #(
   parameter int  WIDTH   = 8,
   parameter int  NUM_OUT = 2,
   parameter int  DEPTH   = 2,
   localparam int SEL_W   = (NUM_OUT > 2) ? $clog2(NUM_OUT) : 1,
   localparam int CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           in_data,
   input  logic [SEL_W-1:0]           in_sel,
   input  logic                       in_bcast,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [NUM_OUT*WIDTH-1:0]   out_data,
   output logic [NUM_OUT-1:0]         out_valid,
   input  logic [NUM_OUT-1:0]         out_ready,
   output logic [NUM_OUT*CNT_W-1:0]   out_level,
   output logic                       bad_sel
);

   localparam int PTR_W = $clog2(DEPTH);

   // Per-channel status and strobes. Each bit is driven by one channel slice.
   logic [NUM_OUT-1:0] full_vec;
   logic [NUM_OUT-1:0] valid_vec;
   logic [NUM_OUT-1:0] push_vec;
   logic [NUM_OUT-1:0] pop_vec;

   logic        run_reg;
   logic        bad_sel_reg;
   logic [31:0] sel_ext;
   logic        sel_bad;
   logic        sel_full;
   logic        accept;

   // Widen the select once so that range checks and channel matches are
   // done at a single width for any NUM_OUT.
   assign sel_ext = 32'(in_sel);
   assign sel_bad = (sel_ext >= 32'(NUM_OUT));

   // Holds in_ready low during reset. It goes high on the first edge after
   // rst_n is released, so in_ready depends only on registered state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_reg <= 1'b0;
      end else begin
         run_reg <= 1'b1;
      end
   end

   // Look up the fullness of the addressed channel. An out-of-range select
   // matches no channel and leaves sel_full at 0.
   always_comb begin
      sel_full = 1'b0;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (sel_ext == 32'(k)) begin
            sel_full = full_vec[k];
         end
      end
   end

   // Ready is built from levels only. A channel that pops this cycle does
   // not open the path, so there is no out_ready -> in_ready timing arc.
   // A broadcast needs room in every channel, so it writes all or nothing.
   // A word with a bad unicast select is always taken, then dropped.
   always_comb begin
      in_ready = 1'b0;
      if (run_reg) begin
         if (in_bcast) begin
            in_ready = ~|full_vec;
         end else begin
            in_ready = sel_bad | ~sel_full;
         end
      end
   end

   assign accept = in_valid & in_ready;

   // Sticky error flag for a unicast word addressed past the last channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bad_sel_reg <= 1'b0;
      end else if (accept && !in_bcast && sel_bad) begin
         bad_sel_reg <= 1'b1;
      end
   end

   assign bad_sel   = bad_sel_reg;
   assign out_valid = valid_vec;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OUT; gi++) begin : gen_ch
         logic [WIDTH-1:0] mem [DEPTH];
         logic [PTR_W-1:0] wr_ptr_reg;
         logic [PTR_W-1:0] rd_ptr_reg;
         logic [CNT_W-1:0] level_reg;

         assign full_vec[gi]  = (level_reg == CNT_W'(DEPTH));
         assign valid_vec[gi] = (level_reg != '0);
         assign push_vec[gi]  = accept & (in_bcast | (sel_ext == 32'(gi)));
         assign pop_vec[gi]   = valid_vec[gi] & out_ready[gi];

         // Storage array. It has no reset, because a slot is read only
         // after it has been written.
         always_ff @(posedge clk) begin
            if (push_vec[gi]) begin
               mem[wr_ptr_reg] <= in_data;
            end
         end

         // Pointers wrap modulo DEPTH. level counts 0..DEPTH inclusive and
         // does not change when a push and a pop happen on the same edge.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               level_reg  <= '0;
            end else begin
               if (push_vec[gi]) begin
                  wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
               end
               if (pop_vec[gi]) begin
                  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
               end
               case ({push_vec[gi], pop_vec[gi]})
                  2'b10:   level_reg <= level_reg + CNT_W'(1);
                  2'b01:   level_reg <= level_reg - CNT_W'(1);
                  default: level_reg <= level_reg;
               endcase
            end
         end

         // Show the head word only while the channel holds data. Otherwise
         // drive zeros, so an idle channel never shows stale or unwritten
         // storage.
         assign out_data[gi*WIDTH +: WIDTH]  = valid_vec[gi] ? mem[rd_ptr_reg] : '0;
         assign out_level[gi*CNT_W +: CNT_W] = level_reg;
      end
   endgenerate

endmodule

// File: tb/tb_demux_stream.sv
// Testbench for demux_stream with NUM_OUT=3, DEPTH=2, WIDTH=8. A per-channel
// scoreboard follows every accept and pop. Scenario tasks check in_ready,
// levels, flags and output words directly.
module tb_demux_stream;

   localparam int WIDTH   = 8;
   localparam int NUM_OUT = 3;
   localparam int DEPTH   = 2;
   localparam int SEL_W   = 2;
   localparam int CNT_W   = 2;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [WIDTH-1:0]         in_data = '0;
   logic [SEL_W-1:0]         in_sel = '0;
   logic                     in_bcast = 1'b0;
   logic                     in_valid = 1'b0;
   logic                     in_ready;
   logic [NUM_OUT*WIDTH-1:0] out_data;
   logic [NUM_OUT-1:0]       out_valid;
   logic [NUM_OUT-1:0]       out_ready = '0;
   logic [NUM_OUT*CNT_W-1:0] out_level;
   logic                     bad_sel;

   int tests_run = 0;
   int tests_failed = 0;

   logic [WIDTH-1:0] sb_q [NUM_OUT][$];

   demux_stream #(.WIDTH(WIDTH), .NUM_OUT(NUM_OUT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
      .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_level(out_level), .bad_sel(bad_sel)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one clock. At the falling edge the scoreboard checks every
   // channel, retires the pops and records the accepts. The task returns 1
   // time unit after the rising edge.
   task automatic step_cycle();
      logic [WIDTH-1:0] d;
      int sz;
      @(negedge clk);
      for (int k = 0; k < NUM_OUT; k++) begin
         d  = out_data[k*WIDTH +: WIDTH];
         sz = sb_q[k].size();
         tests_run++;
         if (out_valid[k] !== (sz != 0)) begin
            tests_failed++;
            $display("FAIL sb_valid ch%0d: got %b, expected %b", k, out_valid[k], (sz != 0));
         end
         tests_run++;
         if (out_level[k*CNT_W +: CNT_W] !== CNT_W'(sz)) begin
            tests_failed++;
            $display("FAIL sb_level ch%0d: got %0d, expected %0d", k, out_level[k*CNT_W +: CNT_W], sz);
         end
         tests_run++;
         if (sz != 0) begin
            if (d !== sb_q[k][0]) begin
               tests_failed++;
               $display("FAIL sb_data ch%0d: got %h, expected %h", k, d, sb_q[k][0]);
            end
            if (out_valid[k] && out_ready[k]) begin
               $display("[TB] pop  ch%0d data %h", k, d);
               void'(sb_q[k].pop_front());
            end
         end else if (d !== '0) begin
            tests_failed++;
            $display("FAIL sb_idle_zero ch%0d: got %h, expected 00", k, d);
         end
      end
      if (in_valid && in_ready) begin
         if (in_bcast) begin
            $display("[TB] push bcast data %h", in_data);
            for (int k = 0; k < NUM_OUT; k++) sb_q[k].push_back(in_data);
         end else if (int'(in_sel) < NUM_OUT) begin
            $display("[TB] push ch%0d data %h", in_sel, in_data);
            sb_q[in_sel].push_back(in_data);
         end else begin
            $display("[TB] push bad sel %0d data %h dropped", in_sel, in_data);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
      tests_run++;
      if (out_valid !== 3'b000) begin tests_failed++; $display("FAIL reset_out_valid: got %b, expected 000", out_valid); end
      tests_run++;
      if (out_level !== 6'd0) begin tests_failed++; $display("FAIL reset_out_level: got %h, expected 00", out_level); end
      tests_run++;
      if (out_data !== 24'd0) begin tests_failed++; $display("FAIL reset_out_data: got %h, expected 000000", out_data); end
      tests_run++;
      if (bad_sel !== 1'b0) begin tests_failed++; $display("FAIL reset_bad_sel: got %b, expected 0", bad_sel); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready: got %b, expected 1", in_ready); end
   endtask

   task automatic test_unicast();
      out_ready = 3'b111;
      in_valid = 1'b1; in_data = 8'h11; in_sel = 2'd0;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL uni_ready0: got %b, expected 1", in_ready); end
      step_cycle();
      in_data = 8'h22; in_sel = 2'd2;
      #1;
      tests_run++;
      if (out_valid !== 3'b001) begin tests_failed++; $display("FAIL uni_valid0: got %b, expected 001", out_valid); end
      tests_run++;
      if (out_data !== 24'h000011) begin tests_failed++; $display("FAIL uni_data0: got %h, expected 000011", out_data); end
      step_cycle();
      in_data = 8'h33; in_sel = 2'd1;
      #1;
      tests_run++;
      if (out_valid !== 3'b100) begin tests_failed++; $display("FAIL uni_valid2: got %b, expected 100", out_valid); end
      tests_run++;
      if (out_data !== 24'h220000) begin tests_failed++; $display("FAIL uni_data2: got %h, expected 220000", out_data); end
      step_cycle();
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 3'b010) begin tests_failed++; $display("FAIL uni_valid1: got %b, expected 010", out_valid); end
      tests_run++;
      if (out_data !== 24'h003300) begin tests_failed++; $display("FAIL uni_data1: got %h, expected 003300", out_data); end
      step_cycle();
      tests_run++;
      if (out_valid !== 3'b000) begin tests_failed++; $display("FAIL uni_idle: got %b, expected 000", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 3'b110;
      in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hA1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_a1: got %b, expected 1", in_ready); end
      step_cycle();
      in_data = 8'hA2;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_a2: got %b, expected 1", in_ready); end
      step_cycle();
      in_data = 8'hA3;
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_a3_full: got %b, expected 0", in_ready); end
      tests_run++;
      if (out_level[1:0] !== 2'd2) begin tests_failed++; $display("FAIL bp_level0: got %0d, expected 2", out_level[1:0]); end
      step_cycle();
      in_data = 8'hB1; in_sel = 2'd1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_ch1: got %b, expected 1", in_ready); end
      step_cycle();
      in_data = 8'hA3; in_sel = 2'd0; out_ready = 3'b111;
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_no_bypass: got %b, expected 0", in_ready); end
      tests_run++;
      if (out_data[15:8] !== 8'hB1) begin tests_failed++; $display("FAIL bp_ch1_data: got %h, expected b1", out_data[15:8]); end
      step_cycle();
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_after_pop: got %b, expected 1", in_ready); end
      tests_run++;
      if (out_data[7:0] !== 8'hA2) begin tests_failed++; $display("FAIL bp_head_a2: got %h, expected a2", out_data[7:0]); end
      step_cycle();
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (out_data[7:0] !== 8'hA3) begin tests_failed++; $display("FAIL bp_head_a3: got %h, expected a3", out_data[7:0]); end
      step_cycle();
      tests_run++;
      if (out_valid !== 3'b000) begin tests_failed++; $display("FAIL bp_drained: got %b, expected 000", out_valid); end
   endtask

   task automatic test_bcast_full();
      out_ready = 3'b011;
      in_valid = 1'b1; in_sel = 2'd2; in_bcast = 1'b0; in_data = 8'hC1;
      step_cycle();
      in_data = 8'hC2;
      step_cycle();
      in_bcast = 1'b1; in_sel = 2'd1; in_data = 8'h5C;
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bc_ready_full: got %b, expected 0", in_ready); end
      step_cycle();
      tests_run++;
      if (out_level !== {2'd2, 2'd0, 2'd0}) begin tests_failed++; $display("FAIL bc_no_partial: got %h, expected 20", out_level); end
      out_ready = 3'b111;
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bc_ready_popping: got %b, expected 0", in_ready); end
      step_cycle();
      out_ready = 3'b011;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bc_ready_room: got %b, expected 1", in_ready); end
      step_cycle();
      in_valid = 1'b0; in_bcast = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 3'b111) begin tests_failed++; $display("FAIL bc_valid_all: got %b, expected 111", out_valid); end
      tests_run++;
      if (out_data !== 24'hC25C5C) begin tests_failed++; $display("FAIL bc_data: got %h, expected c25c5c", out_data); end
      tests_run++;
      if (out_level !== {2'd2, 2'd1, 2'd1}) begin tests_failed++; $display("FAIL bc_levels: got %h, expected 25", out_level); end
      out_ready = 3'b111;
      step_cycle();
      tests_run++;
      if (out_data !== 24'h5C0000) begin tests_failed++; $display("FAIL bc_ch2_tail: got %h, expected 5c0000", out_data); end
      step_cycle();
      tests_run++;
      if (out_valid !== 3'b000) begin tests_failed++; $display("FAIL bc_drained: got %b, expected 000", out_valid); end
   endtask

   task automatic test_push_pop();
      logic [WIDTH-1:0] exp_head;
      out_ready = 3'b111;
      in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hD0;
      step_cycle();
      for (int i = 0; i < 2*DEPTH+1; i++) begin
         in_data = 8'(8'hD1 + i);
         exp_head = 8'(8'hD0 + i);
         #1;
         tests_run++;
         if (out_level[1:0] !== 2'd1) begin tests_failed++; $display("FAIL pp_level it%0d: got %0d, expected 1", i, out_level[1:0]); end
         tests_run++;
         if (out_data[7:0] !== exp_head) begin tests_failed++; $display("FAIL pp_head it%0d: got %h, expected %h", i, out_data[7:0], exp_head); end
         step_cycle();
      end
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (out_data[7:0] !== 8'hD5) begin tests_failed++; $display("FAIL pp_last: got %h, expected d5", out_data[7:0]); end
      step_cycle();
      tests_run++;
      if (out_valid !== 3'b000) begin tests_failed++; $display("FAIL pp_drained: got %b, expected 000", out_valid); end
   endtask

   task automatic test_bad_sel();
      out_ready = 3'b111;
      tests_run++;
      if (bad_sel !== 1'b0) begin tests_failed++; $display("FAIL bs_initial: got %b, expected 0", bad_sel); end
      in_valid = 1'b1; in_sel = 2'd3; in_data = 8'h77;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bs_ready: got %b, expected 1", in_ready); end
      step_cycle();
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (bad_sel !== 1'b1) begin tests_failed++; $display("FAIL bs_set: got %b, expected 1", bad_sel); end
      tests_run++;
      if (out_valid !== 3'b000) begin tests_failed++; $display("FAIL bs_dropped: got %b, expected 000", out_valid); end
      step_cycle();
      tests_run++;
      if (bad_sel !== 1'b1) begin tests_failed++; $display("FAIL bs_held: got %b, expected 1", bad_sel); end
      in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h78;
      step_cycle();
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (out_data !== 24'h007800) begin tests_failed++; $display("FAIL bs_next_route: got %h, expected 007800", out_data); end
      step_cycle();
   endtask

   task automatic test_reset_mid();
      out_ready = 3'b000;
      in_valid = 1'b1; in_sel = 2'd0; in_data = 8'hE0;
      step_cycle();
      in_sel = 2'd1; in_data = 8'hE1;
      step_cycle();
      in_valid = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 3'b011) begin tests_failed++; $display("FAIL rm_loaded: got %b, expected 011", out_valid); end
      #1;
      rst_n = 1'b0;
      for (int k = 0; k < NUM_OUT; k++) sb_q[k].delete();
      #1;
      tests_run++;
      if (out_valid !== 3'b000) begin tests_failed++; $display("FAIL rm_valid: got %b, expected 000", out_valid); end
      tests_run++;
      if (out_level !== 6'd0) begin tests_failed++; $display("FAIL rm_level: got %h, expected 00", out_level); end
      tests_run++;
      if (bad_sel !== 1'b0) begin tests_failed++; $display("FAIL rm_bad_sel: got %b, expected 0", bad_sel); end
      tests_run++;
      if (out_data !== 24'd0) begin tests_failed++; $display("FAIL rm_data: got %h, expected 000000", out_data); end
      tests_run++;
      if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rm_ready_low: got %b, expected 0", in_ready); end
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rm_ready_release: got %b, expected 1", in_ready); end
      out_ready = 3'b111;
      step_cycle();
      tests_run++;
      if (out_valid !== 3'b000) begin tests_failed++; $display("FAIL rm_empty: got %b, expected 000", out_valid); end
   endtask

   initial begin
      test_reset();
      test_unicast();
      test_backpressure();
      test_bcast_full();
      test_push_pop();
      test_bad_sel();
      test_reset_mid();
      for (int k = 0; k < NUM_OUT; k++) begin
         tests_run++;
         if (sb_q[k].size() != 0) begin
            tests_failed++;
            $display("FAIL sb_leftover ch%0d: got %0d, expected 0", k, sb_q[k].size());
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
